// File: rtl/beu_clmul_seq.sv
// beu_clmul_seq: iterative Zbc carry-less multiply (clmul/clmulh/clmulr), BITS_PER_CYCLE op2 bits per RUN edge.
// Define BEU_CLMUL_ZERO_SKIP_EN to finish early once the remaining multiplier bits are all zero.
module beu_clmul_seq #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic        s_clk_i,
  input  logic        s_reset_i,
  input  logic        s_start_i,
  input  logic [1:0]  s_func_i,
  input  logic [31:0] s_op1_i,
  input  logic [31:0] s_op2_i,
  input  logic        s_flush_i,
  input  logic        s_ack_i,
  output logic        s_busy_o,
  output logic        s_valid_o,
  output logic [31:0] s_result_o
);
  localparam int N  = 32 / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        r_state, w_state_nx;
  logic [63:0]   r_op1, r_prod, w_prod_step;
  logic [31:0]   r_op2, w_op2_step, w_res;
  logic [1:0]    r_func;
  logic [CW-1:0] r_cnt;
  logic          w_last, w_op2_zero;
  always_comb begin
    w_prod_step = r_prod;
    for (int j = 0; j < BITS_PER_CYCLE; j++)
      w_prod_step = w_prod_step ^ (r_op2[j] ? (r_op1 << j) : 64'd0);
  end
  assign w_op2_step = r_op2 >> BITS_PER_CYCLE;
`ifdef BEU_CLMUL_ZERO_SKIP_EN
  assign w_last     = (r_cnt == CW'(N - 1)) || (w_op2_step == '0);
  assign w_op2_zero = (s_op2_i == '0);
`else
  assign w_last     = (r_cnt == CW'(N - 1));
  assign w_op2_zero = 1'b0;
`endif
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (s_start_i) w_state_nx = (s_func_i == 2'b11 || w_op2_zero) ? DONE : RUN;
      RUN:     if (w_last) w_state_nx = DONE;
      DONE:    if (s_ack_i) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
    if (s_flush_i) w_state_nx = IDLE;
  end
  always_ff @(posedge s_clk_i)
    r_state <= s_reset_i ? IDLE : w_state_nx;
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      r_op1  <= '0;
      r_op2  <= '0;
      r_func <= '0;
      r_prod <= '0;
      r_cnt  <= '0;
    end else if (!s_flush_i) begin
      if (r_state == IDLE && s_start_i) begin
        r_op1  <= {32'd0, s_op1_i};
        r_op2  <= s_op2_i;
        r_func <= s_func_i;
        r_prod <= '0;
        r_cnt  <= '0;
      end else if (r_state == RUN) begin
        r_prod <= w_prod_step;
        r_op1  <= r_op1 << BITS_PER_CYCLE;
        r_op2  <= w_op2_step;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end
  assign w_res = (r_func == 2'b00) ? r_prod[31:0]  :
                 (r_func == 2'b01) ? r_prod[63:32] :
                 (r_func == 2'b10) ? r_prod[62:31] : 32'd0;
  assign s_busy_o   = (r_state != IDLE);
  assign s_valid_o  = (r_state == DONE);
  assign s_result_o = s_valid_o ? w_res : 32'd0;
endmodule
